// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer pot path.
package eq_pkg;
    localparam int POT_W       = 12;
    localparam int ADC_FRAME_W = 16;
    localparam int MAX_ADC_CH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        SHIFT,
        BACK,
        GAP
    } adc_state_t;

    typedef logic [POT_W-1:0] pot_t;
endpackage

// File: rtl/spi_frame_master.sv
// Mode-3 SPI master moving one 16-bit frame per pass, with chip-select
// framing and an inter-frame gap.
module spi_frame_master
    import eq_pkg::*;
#(
    parameter int SCLK_DIV = 32,
    parameter int GAP_LEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADC_FRAME_W-1:0] tx_word,
    output logic [ADC_FRAME_W-1:0] rx_word,
    output logic                   done,
    output logic                   SS_n,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO
);
    localparam int         HALF   = SCLK_DIV / 2;
    localparam logic [15:0] C_HALF = 16'(HALF - 1);
    localparam logic [15:0] C_DIV  = 16'(SCLK_DIV - 1);
    localparam logic [15:0] C_GAP  = 16'(GAP_LEN - 1);

    adc_state_t r_state, w_state_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [3:0]  r_bit, w_bit_nx;
    logic [ADC_FRAME_W-1:0] r_tx, r_rx;
    logic r_ss_n, r_sclk, r_done;
    logic w_load, w_fall, w_rise, w_end;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 16'd1;
        w_bit_nx   = r_bit;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (start) w_state_nx = FRONT;
            end
            FRONT: if (r_cnt == C_HALF) begin
                w_state_nx = SHIFT;
                w_cnt_nx   = '0;
                w_bit_nx   = '0;
            end
            SHIFT: if (r_cnt == C_DIV) begin
                w_cnt_nx = '0;
                if (r_bit == 4'd15) w_state_nx = BACK;
                else w_bit_nx = r_bit + 4'd1;
            end
            BACK: if (r_cnt == C_HALF) begin
                w_state_nx = GAP;
                w_cnt_nx   = '0;
            end
            GAP: if (r_cnt == C_GAP) begin
                w_cnt_nx   = '0;
                w_state_nx = start ? FRONT : IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Events are decoded one clk ahead so the pins come straight from flops.
    assign w_load = (w_state_nx == FRONT) && (r_state != FRONT);
    assign w_fall = (r_state == SHIFT) && (r_cnt == C_DIV) &&
                    (r_bit != 4'd15);
    assign w_rise = (r_state == SHIFT) && (r_cnt == C_HALF);
    assign w_end  = (r_state == BACK) && (w_state_nx == GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_ss_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_ss_n  <= !(w_state_nx inside {FRONT, SHIFT, BACK});
            r_sclk  <= !((w_state_nx == SHIFT) &&
                         (w_cnt_nx < 16'(HALF)));
            r_done  <= w_end;
            if (w_load) r_tx <= tx_word;
            else if (w_fall) r_tx <= {r_tx[ADC_FRAME_W-2:0], 1'b0};
            else if (w_end) r_tx <= '0;
            if (w_rise) r_rx <= {r_rx[ADC_FRAME_W-2:0], MISO};
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = r_sclk;
    assign MOSI    = r_tx[ADC_FRAME_W-1];
    assign rx_word = r_rx;
    assign done    = r_done;
endmodule

// File: rtl/pot_adc_reader.sv
// Round-robin scanner for the slide-pot ADC; holds the latest 12-bit
// reading of every channel for the band gain stages.
module pot_adc_reader
    import eq_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int SCLK_DIV = 32,
    parameter int GAP      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    SS_n,
    output logic                    SCLK,
    output logic                    MOSI,
    input  logic                    MISO,
    output logic [NUM_CH*POT_W-1:0] pots,
    output logic                    upd,
    output logic [2:0]              upd_ch,
    output logic                    all_valid
);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    logic [ADC_FRAME_W-1:0] w_tx_word, w_rx_word;
    logic w_done, w_commit, w_unused;
    logic [2:0] r_addr, r_prev, w_addr_inc, w_tx_addr;
    logic r_primed, r_upd, r_all;
    logic [2:0] r_upd_ch;
    logic [MAX_ADC_CH-1:0] r_seen, w_seen_nx;

    assign w_addr_inc = (r_addr == LAST_CH) ? 3'd0 : r_addr + 3'd1;
    // With a 1-clk gap the next frame loads while done is still high.
    assign w_tx_addr  = w_done ? w_addr_inc : r_addr;
    assign w_tx_word  = {2'b00, w_tx_addr, 11'b0};
    assign w_commit   = w_done && r_primed;
    assign w_seen_nx  = r_seen | (MAX_ADC_CH'(1) << r_prev);
    assign w_unused   = ^w_rx_word[ADC_FRAME_W-1:POT_W];

    spi_frame_master #(
        .SCLK_DIV(SCLK_DIV),
        .GAP_LEN (GAP)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (1'b1),
        .tx_word(w_tx_word),
        .rx_word(w_rx_word),
        .done   (w_done),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_upd    <= 1'b0;
            r_upd_ch <= '0;
            r_seen   <= '0;
            r_all    <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_done) begin
                r_addr   <= w_addr_inc;
                r_prev   <= r_addr;
                r_primed <= 1'b1;
            end
            if (w_commit) begin
                r_upd    <= 1'b1;
                r_upd_ch <= r_prev;
                r_seen   <= w_seen_nx;
                r_all    <= r_all | (&w_seen_nx[NUM_CH-1:0]);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pot_t r_pot;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_pot <= '0;
            else if (w_commit && (r_prev == 3'(c)))
                r_pot <= w_rx_word[POT_W-1:0];
        end
        assign pots[c*POT_W +: POT_W] = r_pot;
    end

    assign upd       = r_upd;
    assign upd_ch    = r_upd_ch;
    assign all_valid = r_all;
endmodule

// File: tb/tb_pot_adc_reader.sv
// Directed bench: two readers (7-ch default, 1-ch fast) against
// pipelined ADC models with per-channel value tables.
module tb_pot_adc_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic rst_n_a, ss_a, sclk_a, mosi_a, miso_a, upd_a, av_a;
    logic [83:0] pots_a;
    logic [2:0] updch_a;

    logic rst_n_b, ss_b, sclk_b, mosi_b, miso_b, upd_b, av_b;
    logic [11:0] pots_b;
    logic [2:0] updch_b;

    pot_adc_reader u_a (
        .clk(clk), .rst_n(rst_n_a), .SS_n(ss_a), .SCLK(sclk_a),
        .MOSI(mosi_a), .MISO(miso_a), .pots(pots_a), .upd(upd_a),
        .upd_ch(updch_a), .all_valid(av_a)
    );

    pot_adc_reader #(.NUM_CH(1), .SCLK_DIV(4), .GAP(1)) u_b (
        .clk(clk), .rst_n(rst_n_b), .SS_n(ss_b), .SCLK(sclk_b),
        .MOSI(mosi_b), .MISO(miso_b), .pots(pots_b), .upd(upd_b),
        .upd_ch(updch_b), .all_valid(av_b)
    );

    // ADC model A: data of the previously addressed channel, MSB first.
    logic [11:0] tbl_a [8];
    logic [3:0]  hi_a;
    logic [15:0] word_a, din_a;
    logic ss_q_a = 1'b1, sclk_q_a = 1'b1;
    int f_a, nr_a, frm_a, r0_a, r1_a, per_a, prev_a, nupd_a;
    int addr_log_a [64];
    int nr_log_a [64];
    int updch_log_a [64];
    int updt_log_a [64];
    logic av_log_a [64];

    always @(negedge clk) begin
        if (!rst_n_a) begin
            frm_a = 0; nupd_a = 0; nr_a = 0; f_a = 0; prev_a = 7;
        end else begin
            if (ss_q_a && !ss_a) begin
                word_a = {hi_a, tbl_a[prev_a]};
                miso_a = word_a[15];
                f_a = 0; nr_a = 0; din_a = '0;
            end
            if (!ss_a && sclk_q_a && !sclk_a && f_a < 16) begin
                miso_a = word_a[15-f_a];
                f_a++;
            end
            if (!ss_a && !sclk_q_a && sclk_a) begin
                din_a = {din_a[14:0], mosi_a};
                if (nr_a == 0) r0_a = cyc;
                if (nr_a == 1) r1_a = cyc;
                nr_a++;
            end
            if (!ss_q_a && ss_a) begin
                if (frm_a < 64) begin
                    addr_log_a[frm_a] = int'(din_a[13:11]);
                    nr_log_a[frm_a] = nr_a;
                end
                per_a = r1_a - r0_a;
                prev_a = int'(din_a[13:11]);
                frm_a++;
            end
            if (upd_a) begin
                if (nupd_a < 64) begin
                    updch_log_a[nupd_a] = int'(updch_a);
                    updt_log_a[nupd_a] = cyc;
                    av_log_a[nupd_a] = av_a;
                end
                nupd_a++;
            end
        end
        ss_q_a = ss_a;
        sclk_q_a = sclk_a;
    end

    // ADC model B: single channel, frame 0 returns junk.
    logic [11:0] tbl_b;
    logic [15:0] word_b, din_b;
    logic ss_q_b = 1'b1, sclk_q_b = 1'b1;
    int f_b, frm_b, nupd_b;
    int addr_log_b [64];
    int updt_log_b [64];

    always @(negedge clk) begin
        if (!rst_n_b) begin
            frm_b = 0; nupd_b = 0; f_b = 0;
        end else begin
            if (ss_q_b && !ss_b) begin
                word_b = {4'h0, (frm_b == 0) ? 12'hBAD : tbl_b};
                miso_b = word_b[15];
                f_b = 0; din_b = '0;
            end
            if (!ss_b && sclk_q_b && !sclk_b && f_b < 16) begin
                miso_b = word_b[15-f_b];
                f_b++;
            end
            if (!ss_b && !sclk_q_b && sclk_b)
                din_b = {din_b[14:0], mosi_b};
            if (!ss_q_b && ss_b) begin
                if (frm_b < 64) addr_log_b[frm_b] = int'(din_b[13:11]);
                frm_b++;
            end
            if (upd_b) begin
                if (nupd_b < 64) updt_log_b[nupd_b] = cyc;
                nupd_b++;
            end
        end
        ss_q_b = ss_b;
        sclk_q_b = sclk_b;
    end

    function automatic logic [11:0] pa(input int c);
        return pots_a[c*12 +: 12];
    endfunction

    task automatic wait_frm_a(input int n);
        int k = 0;
        while (frm_a < n && k < 8000) begin @(negedge clk); k++; end
        if (frm_a < n) check("tmo_frm_a", frm_a, n);
    endtask

    task automatic wait_upd_a(input int n);
        int k = 0;
        while (nupd_a < n && k < 8000) begin @(negedge clk); k++; end
        if (nupd_a < n) check("tmo_upd_a", nupd_a, n);
    endtask

    task automatic wait_frm_b(input int n);
        int k = 0;
        while (frm_b < n && k < 2000) begin @(negedge clk); k++; end
        if (frm_b < n) check("tmo_frm_b", frm_b, n);
    endtask

    task automatic wait_upd_b(input int n);
        int k = 0;
        while (nupd_b < n && k < 2000) begin @(negedge clk); k++; end
        if (nupd_b < n) check("tmo_upd_b", nupd_b, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        miso_a = 1'b0; miso_b = 1'b0;
        hi_a = 4'h0;
        tbl_a[0] = 12'h000; tbl_a[1] = 12'h123; tbl_a[2] = 12'h456;
        tbl_a[3] = 12'h789; tbl_a[4] = 12'hABC; tbl_a[5] = 12'hDEF;
        tbl_a[6] = 12'hFFF; tbl_a[7] = 12'hBAD;
        tbl_b = 12'h6C3;
        repeat (3) @(negedge clk);

        check("rst_ss", ss_a, 1);
        check("rst_sclk", sclk_a, 1);
        check("rst_mosi", mosi_a, 0);
        check("rst_pots", pots_a == '0, 1);
        check("rst_upd", upd_a, 0);
        check("rst_updch", updch_a, 0);
        check("rst_av", av_a, 0);

        rst_n_a = 1'b1;
        #1 check("idle_ss", ss_a, 1);
        @(negedge clk);
        check("first_ss_fall", ss_a, 0);

        wait_frm_a(1);
        repeat (4) @(negedge clk);
        check("f0_rises", nr_log_a[0], 16);
        check("sclk_period", per_a, 32);
        check("f0_addr", addr_log_a[0], 0);
        check("f0_no_upd", nupd_a, 0);
        wait_frm_a(2);
        check("f1_addr", addr_log_a[1], 1);

        wait_frm_a(8);
        repeat (3) @(negedge clk);
        check("scan_nupd", nupd_a, 7);
        for (int c = 0; c < 7; c++) begin
            check($sformatf("pot%0d", c), pa(c), tbl_a[c]);
            check($sformatf("updch%0d", c), updch_log_a[c], c);
        end
        check("av_6th", av_log_a[5], 0);
        check("av_7th", av_log_a[6], 1);
        check("upd_space", updt_log_a[6] - updt_log_a[5], 576);
        check("av_now", av_a, 1);

        hi_a = 4'hF;
        tbl_a[4] = 12'h3A5;
        n = nupd_a;
        wait_upd_a(n + 8);
        repeat (2) @(negedge clk);
        check("hi_nib_pot4", pa(4), 12'h3A5);
        check("hi_nib_pot3", pa(3), 12'h789);
        check("hi_nib_pot6", pa(6), 12'hFFF);

        tbl_a[2] = 12'h800;
        check("pot2_hold", pa(2), 12'h456);
        n = nupd_a;
        wait_upd_a(n + 8);
        repeat (2) @(negedge clk);
        check("pot2_new", pa(2), 12'h800);
        check("pot1_keep", pa(1), 12'h123);
        check("pot5_keep", pa(5), 12'hDEF);

        k = 0;
        while (!(nr_a == 7 && !sclk_a && !ss_a) && k < 2000) begin
            @(negedge clk); k++;
        end
        check("mid_shift_found", nr_a == 7 && !sclk_a && !ss_a, 1);
        rst_n_a = 1'b0;
        #1;
        check("mrst_ss", ss_a, 1);
        check("mrst_sclk", sclk_a, 1);
        check("mrst_pots", pots_a == '0, 1);
        check("mrst_av", av_a, 0);
        check("mrst_updch", updch_a, 0);
        tbl_a[0] = 12'h5A5;
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        wait_frm_a(1);
        repeat (4) @(negedge clk);
        check("r_f0_addr", addr_log_a[0], 0);
        check("r_f0_no_upd", nupd_a, 0);
        check("r_f0_pot0", pa(0), 12'h000);
        wait_frm_a(2);
        repeat (3) @(negedge clk);
        check("r_f1_addr", addr_log_a[1], 1);
        check("r_f1_nupd", nupd_a, 1);
        check("r_f1_updch", updch_log_a[0], 0);
        check("r_f1_pot0", pa(0), 12'h5A5);

        rst_n_b = 1'b1;
        wait_frm_b(1);
        repeat (3) @(negedge clk);
        check("b_f0_no_upd", nupd_b, 0);
        check("b_f0_addr", addr_log_b[0], 0);
        wait_upd_b(3);
        repeat (2) @(negedge clk);
        check("b_f1_addr", addr_log_b[1], 0);
        check("b_f2_addr", addr_log_b[2], 0);
        check("b_space1", updt_log_b[1] - updt_log_b[0], 69);
        check("b_space2", updt_log_b[2] - updt_log_b[1], 69);
        check("b_pot", pots_b, 12'h6C3);
        check("b_av", av_b, 1);
        tbl_b = 12'h19E;
        n = nupd_b;
        wait_upd_b(n + 2);
        repeat (2) @(negedge clk);
        check("b_pot_track", pots_b, 12'h19E);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
